uart_sample_framer: RTL and testbench
=====================================

# uart_sample_framer

Frame parser downstream of `uart_rx`. It consumes the received byte stream, hunts for a sync byte, and assembles little-endian 16-bit audio samples into a local frame buffer. It validates each frame with an XOR checksum and presents only good frames to the visualizer datapath, which reads them through a random-access port and acknowledges each one.

## Interface
- `FRAME_SAMPLES`, 64: samples per frame; power of two, at least 2.
- `TIMEOUT_CYCLES`, 4400: maximum idle clocks between bytes inside a frame (about 2 byte times at 115200 baud on a 25.2 MHz clock).
- `SYNC_BYTE`, 8'hA5: frame start marker.

Ports:
- `clk`, in, 1: single clock.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `byte_valid`, in, 1: one-cycle pulse per received byte; driven by `uart_rx` `data_valid`.
- `byte_data`, in, 8: received byte, valid while `byte_valid` is high.
- `frame_valid`, out, 1: a checked frame is held in the buffer.
- `frame_ack`, in, 1: consumer releases the held frame.
- `rd_addr`, in, $clog2(FRAME_SAMPLES): sample index to read.
- `rd_data`, out, 16: sample at `rd_addr`, registered.
- `csum_err`, out, 1: one-cycle pulse when a frame fails its checksum.
- `overrun`, out, 1: one-cycle pulse when `SYNC_BYTE` arrives while a frame is held.
- `timeout`, out, 1: one-cycle pulse when a frame is abandoned because the line went idle.

## Operation
- Wire format: `SYNC_BYTE`, then FRAME_SAMPLES × (lo byte, hi byte), then a checksum byte equal to the XOR of all payload bytes. The sync byte is excluded from the checksum.
- FSM states:
  - HUNT: discard every byte except `SYNC_BYTE`. On sync, clear the sample index and the running XOR, then go to LO.
  - LO: latch the low byte, then go to HI.
  - HI: write {hi, lo} to buffer[index]. If index = FRAME_SAMPLES-1, go to CSUM; otherwise increment index and go to LO.
  - CSUM: if the byte equals the running XOR, go to HOLD. Otherwise pulse `csum_err` and go to HUNT.
  - HOLD: `frame_valid`=1. On `frame_ack`, go to HUNT. Bytes received here are dropped; a `SYNC_BYTE` among them also pulses `overrun`.
- Running XOR updates on every payload byte in LO and HI.
- The payload byte value 0xA5 is ordinary data in LO, HI and CSUM; no resynchronization occurs inside a frame.
- Timeout counter: cleared on entry to LO and on every accepted byte; counts only in LO, HI and CSUM. When it reaches TIMEOUT_CYCLES, pulse `timeout` and go to HUNT.
- `frame_ack` is ignored outside HOLD.
- `frame_ack` and `byte_valid` in the same HOLD cycle: go to HUNT and drop the byte, even if it is sync.
- Buffer contents are undefined after an error; they are only meaningful while `frame_valid` is high.

## Timing
- Reset values: state HUNT, `frame_valid`=0, `rd_data`=0, `csum_err`=`overrun`=`timeout`=0; counters cleared. Asserting reset mid-frame abandons the frame immediately.
- `frame_valid` rises in the cycle after the `byte_valid` that carries a good checksum.
- `frame_valid` falls in the cycle after `frame_ack`.
- `csum_err` pulses in the cycle after the bad checksum byte.
- `rd_data` has 1-cycle latency from `rd_addr`, and is valid for any address while `frame_valid`=1.
- Sample write lands in the cycle after the hi byte's `byte_valid`, so reads of that address are valid from the following cycle.
- Throughput: one byte per clock is accepted with no stall. No back-pressure to `uart_rx` exists.

## Structure
- Shared package `uart_pkg` holds the FSM state encoding (HUNT, LO, HI, CSUM, HOLD) and the default `SYNC_BYTE`.
- Sub-module `frame_buffer_ram`: simple dual-port, FRAME_SAMPLES × 16, one write port and one registered read port. It should infer block RAM.
- Top level holds the FSM, index, XOR accumulator and timeout counter.

## Test plan
All scenarios use FRAME_SAMPLES=4.
- Good frame: A5 34 12 78 56 BC 9A F0 DE 00. Required: `frame_valid`=1; reads of addresses 0–3 return 1234, 5678, 9ABC, DEF0; `frame_ack` drops `frame_valid` the next cycle.
- Bad checksum: same frame with checksum 01. Required: one `csum_err` pulse, `frame_valid` stays 0, and the next good frame is accepted.
- Noise then sync: 00 FF A5 followed by a valid payload. Required: leading bytes ignored and the frame accepted. A payload containing A5 (lo byte of sample 0) must read back as sample 0 = 12A5.
- Timeout: A5 34 12, then idle for TIMEOUT_CYCLES. Required: one `timeout` pulse, return to HUNT, and a following good frame is accepted.
- Overrun: a second full frame sent while the first is held and unacknowledged. Required: one `overrun` pulse; after ack, the previously read buffer data is unchanged until a new frame completes.
- Reset mid-frame: `resetn` low after 5 payload bytes. Required: all outputs at reset values, then a clean good-frame receive.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART sample framer.
// Holds the framer FSM encoding, the default sync marker and the sample payload layout.
package uart_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned SAMPLE_W = 16;

  localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Frame parser states
  typedef enum logic [2:0] {
    HUNT = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    CSUM = 3'd3,
    HOLD = 3'd4
  } state_t;

  // One little-endian audio sample as stored in the frame buffer
  typedef struct packed {
    logic [BYTE_W-1:0] hi;
    logic [BYTE_W-1:0] lo;
  } sample_t;

endpackage

// File: rtl/uart_sample_framer_if.sv
// Byte-stream, frame-status and read-port bundle of the UART sample framer.
// Signals:
//   byte_valid/byte_data : received byte strobe and value (from uart_rx)
//   frame_valid          : a checked frame is held in the buffer
//   frame_ack            : consumer releases the held frame
//   rd_addr/rd_data      : random-access sample read, 1-cycle latency
//   csum_err/overrun/timeout : one-cycle status pulses
// Modports: slave = framer, master = producer/consumer side.
interface uart_sample_framer_if #(
  parameter int unsigned FRAME_SAMPLES = 64
) ();

  localparam int unsigned ADDR_W = $clog2(FRAME_SAMPLES);

  logic                          byte_valid;
  logic [uart_pkg::BYTE_W-1:0]   byte_data;
  logic                          frame_valid;
  logic                          frame_ack;
  logic [ADDR_W-1:0]             rd_addr;
  logic [uart_pkg::SAMPLE_W-1:0] rd_data;
  logic                          csum_err;
  logic                          overrun;
  logic                          timeout;

  modport slave (
    input  byte_valid, byte_data, frame_ack, rd_addr,
    output frame_valid, rd_data, csum_err, overrun, timeout
  );

  modport master (
    output byte_valid, byte_data, frame_ack, rd_addr,
    input  frame_valid, rd_data, csum_err, overrun, timeout
  );

endinterface

// File: rtl/frame_buffer_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// Ports:
//   clk, resetn       : clock and async active-low reset (read register only)
//   wr_en/wr_addr/wr_data : synchronous sample write
//   rd_addr/rd_data   : registered read, 1-cycle latency
module frame_buffer_ram
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  // Storage array has no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read output register; a same-cycle write to rd_addr returns the old word
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_sample_framer.sv
// Frame parser behind uart_rx: hunts for the sync byte, assembles little-endian
// 16-bit samples into a frame buffer, checks the XOR checksum and holds good
// frames until the consumer acknowledges them.
// Ports:
//   clk, resetn : clock, async active-low reset
//   bus (slave) : byte stream in, frame status/pulses out, sample read port
module uart_sample_framer
  import uart_pkg::*;
#(
  parameter int unsigned        FRAME_SAMPLES  = 64,
  parameter int unsigned        TIMEOUT_CYCLES = 4400,
  parameter logic [BYTE_W-1:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resetn,
  uart_sample_framer_if.slave  bus
);

  localparam int unsigned ADDR_W = $clog2(FRAME_SAMPLES);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_SAMPLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [BYTE_W-1:0]   lo_q, lo_d;
  logic [BYTE_W-1:0]   xor_q, xor_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                frame_valid_q;
  logic                csum_err_q, csum_err_d;
  logic                overrun_q, overrun_d;
  logic                timeout_q, timeout_d;

  logic                wr_en_c;
  sample_t             wr_data_c;
  logic [SAMPLE_W-1:0] rd_data_c;

  logic                in_frame_c;
  logic                is_sync_c;

  assign in_frame_c = (state_q == LO) || (state_q == HI) || (state_q == CSUM);
  assign is_sync_c  = bus.byte_valid && (bus.byte_data == SYNC_BYTE);

  // Next-state, datapath and status-pulse logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lo_d       = lo_q;
    xor_d      = xor_q;
    tmo_d      = tmo_q;
    csum_err_d = 1'b0;
    overrun_d  = 1'b0;
    timeout_d  = 1'b0;
    wr_en_c    = 1'b0;
    wr_data_c  = '{hi: bus.byte_data, lo: lo_q};

    // Idle-gap watchdog inside a frame; any accepted byte restarts it
    if (in_frame_c) begin
      if (bus.byte_valid) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        timeout_d = 1'b1;
        state_d   = HUNT;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    case (state_q)
      HUNT: begin
        if (is_sync_c) begin
          idx_d   = '0;
          xor_d   = '0;
          tmo_d   = '0;
          state_d = LO;
        end
      end
      LO: begin
        if (bus.byte_valid) begin
          lo_d    = bus.byte_data;
          xor_d   = xor_q ^ bus.byte_data;
          state_d = HI;
        end
      end
      HI: begin
        if (bus.byte_valid) begin
          wr_en_c = 1'b1;
          xor_d   = xor_q ^ bus.byte_data;
          if (idx_q == LAST_IDX) begin
            state_d = CSUM;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = LO;
          end
        end
      end
      CSUM: begin
        if (bus.byte_valid) begin
          if (bus.byte_data == xor_q) begin
            state_d = HOLD;
          end else begin
            csum_err_d = 1'b1;
            state_d    = HUNT;
          end
        end
      end
      HOLD: begin
        // Ack wins over a coincident byte, so a sync in that cycle is not an overrun
        if (bus.frame_ack) begin
          state_d = HUNT;
        end else if (is_sync_c) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = HUNT;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= HUNT;
      idx_q         <= '0;
      lo_q          <= '0;
      xor_q         <= '0;
      tmo_q         <= '0;
      frame_valid_q <= 1'b0;
      csum_err_q    <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      lo_q          <= lo_d;
      xor_q         <= xor_d;
      tmo_q         <= tmo_d;
      frame_valid_q <= (state_d == HOLD);
      csum_err_q    <= csum_err_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
    end
  end

  frame_buffer_ram #(
    .DEPTH (FRAME_SAMPLES)
  ) u_ram (
    .clk     (clk),
    .resetn  (resetn),
    .wr_en   (wr_en_c),
    .wr_addr (idx_q),
    .wr_data (wr_data_c),
    .rd_addr (bus.rd_addr),
    .rd_data (rd_data_c)
  );

  assign bus.frame_valid = frame_valid_q;
  assign bus.rd_data     = rd_data_c;
  assign bus.csum_err    = csum_err_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_uart_sample_framer.sv
// Scoreboard bench for uart_sample_framer with a 4-sample frame.
// Stimulus pushes expected status events and read data into queues; a monitor
// on the falling clock edge pops and compares whenever the DUT shows an event
// or a requested read returns.
module tb_uart_sample_framer;

  localparam int unsigned N      = 4;
  localparam int unsigned TMO    = 50;
  localparam int unsigned ADDR_W = $clog2(N);

  localparam int EV_FV_RISE = 1;
  localparam int EV_FV_FALL = 2;
  localparam int EV_CSUM    = 3;
  localparam int EV_OVERRUN = 4;
  localparam int EV_TIMEOUT = 5;

  localparam logic [79:0] GOOD    = 80'hA5_34_12_78_56_BC_9A_F0_DE_00;
  localparam logic [79:0] BAD     = 80'hA5_34_12_78_56_BC_9A_F0_DE_01;
  localparam logic [79:0] GOOD_A5 = 80'hA5_A5_12_78_56_BC_9A_F0_DE_91;
  localparam logic [63:0] S_GOOD  = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] S_A5    = 64'h12A5_5678_9ABC_DEF0;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  uart_sample_framer_if #(.FRAME_SAMPLES(N)) bus ();

  uart_sample_framer #(
    .FRAME_SAMPLES  (N),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int          evt_q [$];
  logic [15:0] rd_q  [$];
  logic rd_req   = 1'b0;
  logic rd_req_q = 1'b0;
  logic fv_prev  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic seen(input int code);
    if (evt_q.size() == 0) check("event_unexpected", code, 0);
    else check("event", code, evt_q.pop_front());
  endtask

  always @(posedge clk) rd_req_q <= rd_req;

  // Monitor: compare DUT events and read returns against the queues
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.frame_valid && !fv_prev) seen(EV_FV_RISE);
      if (!bus.frame_valid && fv_prev) seen(EV_FV_FALL);
      if (bus.csum_err) seen(EV_CSUM);
      if (bus.overrun)  seen(EV_OVERRUN);
      if (bus.timeout)  seen(EV_TIMEOUT);
      if (rd_req_q) begin
        if (rd_q.size() == 0) check("read_unexpected", int'(bus.rd_data), -1);
        else check("rd_data", int'(bus.rd_data), int'(rd_q.pop_front()));
      end
    end
    fv_prev = bus.frame_valid;
  end

  // All stimulus tasks start and end just after a rising edge
  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [79:0] f);
    for (int i = 9; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic read_exp(input int a, input logic [15:0] e);
    bus.rd_addr = ADDR_W'(a);
    rd_q.push_back(e);
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic read_frame(input logic [63:0] e);
    for (int i = 0; i < 4; i++) read_exp(i, e[63-16*i -: 16]);
  endtask

  task automatic ack();
    evt_q.push_back(EV_FV_FALL);
    bus.frame_ack = 1'b1;
    @(posedge clk); #1;
    bus.frame_ack = 1'b0;
  endtask

  // Bounded wait for all expected events and reads to be consumed
  task automatic drain(input int bound);
    int i = 0;
    while ((evt_q.size() != 0 || rd_q.size() != 0) && i < bound) begin
      @(posedge clk); #1;
      i++;
    end
    check("drain_events", evt_q.size(), 0);
    check("drain_reads", rd_q.size(), 0);
    evt_q.delete();
    rd_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_frame_valid"}, int'(bus.frame_valid), 0);
    check({tag, "_rd_data"},     int'(bus.rd_data), 0);
    check({tag, "_csum_err"},    int'(bus.csum_err), 0);
    check({tag, "_overrun"},     int'(bus.overrun), 0);
    check({tag, "_timeout"},     int'(bus.timeout), 0);
  endtask

  task automatic good_cycle(input logic [79:0] f, input logic [63:0] s);
    evt_q.push_back(EV_FV_RISE);
    send_frame(f);
    drain(20);
    read_frame(s);
    drain(20);
    ack();
    drain(20);
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    bus.frame_ack  = 1'b0;
    bus.rd_addr    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    resetn = 1'b1;
    idle(1);

    // Ack outside HOLD has no effect
    bus.frame_ack = 1'b1;
    idle(1);
    bus.frame_ack = 1'b0;
    idle(2);
    check("ack_in_hunt", int'(bus.frame_valid), 0);

    // Good frame
    good_cycle(GOOD, S_GOOD);

    // Bad checksum, then recovery
    evt_q.push_back(EV_CSUM);
    send_frame(BAD);
    drain(20);
    check("bad_csum_fv", int'(bus.frame_valid), 0);
    good_cycle(GOOD, S_GOOD);

    // Noise before sync, payload containing the sync value
    evt_q.push_back(EV_FV_RISE);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(GOOD_A5);
    drain(20);
    read_frame(S_A5);
    drain(20);
    ack();
    drain(20);

    // Idle line mid-frame
    evt_q.push_back(EV_TIMEOUT);
    send_byte(8'hA5);
    send_byte(8'h34);
    send_byte(8'h12);
    drain(TMO + 20);
    check("timeout_fv", int'(bus.frame_valid), 0);
    good_cycle(GOOD, S_GOOD);

    // Overrun while a frame is held; buffer must keep the held frame
    evt_q.push_back(EV_FV_RISE);
    send_frame(GOOD_A5);
    drain(20);
    read_frame(S_A5);
    drain(20);
    evt_q.push_back(EV_OVERRUN);
    send_frame(GOOD);
    drain(20);
    check("overrun_fv_held", int'(bus.frame_valid), 1);
    // Ack with a coincident sync byte: released, byte dropped, no overrun
    evt_q.push_back(EV_FV_FALL);
    bus.frame_ack  = 1'b1;
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hA5;
    @(posedge clk); #1;
    bus.frame_ack  = 1'b0;
    bus.byte_valid = 1'b0;
    drain(20);
    read_frame(S_A5);
    drain(20);
    check("after_ack_hunt_fv", int'(bus.frame_valid), 0);

    // Reset in the middle of a frame
    send_byte(8'hA5);
    send_byte(8'h34);
    send_byte(8'h12);
    send_byte(8'h78);
    send_byte(8'h56);
    send_byte(8'hBC);
    resetn = 1'b0;
    #2;
    check_idle_outputs("midreset");
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(1);
    good_cycle(GOOD, S_GOOD);

    idle(5);
    check("final_events_left", evt_q.size(), 0);
    check("final_reads_left", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
